ms_uart_bitrx: RTL and testbench
================================

MS_UART_BITRX -- requirements
Module: ms_uart_bitrx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning serial data bits per frame.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two).
REQ-003 The block SHALL have port internalclk  input  1  bit-rate clock; one rising edge per serial bit.
REQ-004 The block SHALL have port RESETN  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port SIN  input  1  serial line, idle high, already synchronous to internalclk.
REQ-006 The block SHALL have port RD  input  1  pop request for the FIFO head entry.
REQ-007 The block SHALL have port DOUT  output  DATA_BITS  data of the FIFO head entry.
REQ-008 The block SHALL have port PERR  output  1  parity-error flag of the FIFO head entry.
REQ-009 The block SHALL have port FERR  output  1  framing-error flag of the FIFO head entry.
REQ-010 The block SHALL have port EMPTY  output  1  FIFO holds no entry.
REQ-011 The block SHALL have port FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 The block SHALL have port OVR  output  1  sticky overrun, a completed frame was dropped.
REQ-013 The block SHALL have port BUSY  output  1  a frame is in progress.

Function
REQ-014 Frame format SHALL be: start 0, DATA_BITS data bits LSB first, even parity bit (XOR of data), stop 1; SIN sampled once per internalclk rising edge.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: SIN=0 -> DATA, bit index cleared; SIN=1 -> stay.
REQ-017 DATA: store SIN at data[index], index+1; after the edge storing bit DATA_BITS-1 -> PARITY.
REQ-018 PARITY: capture perr = SIN XOR (XOR of data) -> STOP.
REQ-019 STOP: push entry {data, perr, ferr = ~SIN}; SIN=1 -> IDLE; SIN=0 -> WAIT_IDLE.
REQ-020 WAIT_IDLE: stay while SIN=0; SIN=1 -> IDLE; no start detection until then.
REQ-021 BUSY SHALL be 1 in DATA, PARITY, STOP, WAIT_IDLE; 0 in IDLE.
REQ-022 Entry SHALL be visible (EMPTY=0, DOUT/PERR/FERR valid) right after the edge that samples the stop bit.
REQ-023 FIFO SHALL be first-word-fall-through; head drives DOUT/PERR/FERR combinationally; when EMPTY these read 0.
REQ-024 RD=1 with EMPTY=0 SHALL pop one entry at the edge; RD with EMPTY=1 SHALL be ignored without error.
REQ-025 Push with FULL=1 and no simultaneous pop SHALL drop the frame and set OVR; FIFO contents unchanged.
REQ-026 Simultaneous push and pop while FULL SHALL accept both; count unchanged; OVR unchanged.
REQ-027 Simultaneous push and pop while EMPTY: the pop SHALL be ignored and the push accepted.
REQ-028 Occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 OVR SHALL stay 1 until reset.

Reset
REQ-030 RESETN=1 SHALL asynchronously force state IDLE, index 0, pointers and count 0, OVR 0, BUSY 0, EMPTY 1, FULL 0, DOUT 0, PERR 0, FERR 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first falling SIN sampled after reset release SHALL be treated as a start bit.

Structure
REQ-032 Package ms_uart_pkg SHALL hold the FSM state encoding, DATA_BITS and FIFO_DEPTH defaults, and the entry width (DATA_BITS+2).
REQ-033 The FIFO SHALL be one sub-module, ms_uart_rxfifo (push, pop, entry in/out, EMPTY, FULL, overflow pulse).

Verification
REQ-034 Frame 0xA5, parity 0, stop 1 -> entry DOUT=0xA5, PERR=0, FERR=0, EMPTY falls after the stop-sample edge.
REQ-035 Frame 0x01 with parity bit 0 -> DOUT=0x01, PERR=1, FERR=0.
REQ-036 Frame 0x3C with stop bit 0, SIN held low 3 more bits -> FERR=1; BUSY stays 1 until SIN=1; no new frame during the low period.
REQ-037 Five back-to-back frames 0x11..0x15, no RD -> FULL after the 4th, OVR=1 after the 5th; reads return 0x11..0x14 in order, then EMPTY=1.
REQ-038 FIFO full, RD=1 on the 5th frame's stop-sample edge -> OVR stays 0; reads return 0x12..0x15.
REQ-039 RESETN pulse after data bit 3 of a frame -> all outputs at reset values; next complete frame 0x5A is received correctly.

Source files
------------

// File: rtl/ms_uart_pkg.sv
// Shared definitions for the bit-rate UART receiver: FSM encoding, default sizes
// and the FIFO entry width.
package ms_uart_pkg;
  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ENTRY_W_DEF    = DATA_BITS_DEF + 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Entry layout is {data, perr, ferr}.
  function automatic int entry_w(input int data_bits);
    return data_bits + 2;
  endfunction
endpackage

// File: rtl/ms_uart_rxfifo.sv
// First-word-fall-through receive FIFO; head is presented combinationally and
// reads as zero while empty.
module ms_uart_rxfifo
  import ms_uart_pkg::*;
#(
  parameter int W     = ENTRY_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         internalclk,
  input  logic         RESETN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign dout    = empty ? '0 : mem[rptr_q];

  always_ff @(posedge internalclk) begin
    if (do_push) mem[wptr_q] <= din;
  end

  always_ff @(posedge internalclk or posedge RESETN) begin
    if (RESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ms_uart_bitrx.sv
// UART frame receiver clocked at the bit rate: start, data LSB first, even
// parity, stop; completed frames land in a small FWFT FIFO.
module ms_uart_bitrx
  import ms_uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 internalclk,
  input  logic                 RESETN,
  input  logic                 SIN,
  input  logic                 RD,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 OVR,
  output logic                 BUSY
);
  localparam int EW = entry_w(DATA_BITS);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, ovr_q, push, ovf;
  logic [EW-1:0]        push_entry, head;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE:      if (!SIN) state_d = ST_DATA;
      ST_DATA:      if (idx_q == LAST_IDX) state_d = ST_PARITY;
      ST_PARITY:    state_d = ST_STOP;
      ST_STOP: begin
        push    = 1'b1;
        state_d = SIN ? ST_IDLE : ST_WAIT_IDLE;
      end
      // Line stuck low after a bad stop: no start detection until it returns high.
      ST_WAIT_IDLE: if (SIN) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge internalclk or posedge RESETN) begin
    if (RESETN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ovf) ovr_q <= 1'b1;
      case (state_q)
        ST_IDLE:   idx_q <= '0;
        ST_DATA: begin
          data_q[idx_q] <= SIN;
          idx_q         <= idx_q + 1'b1;
        end
        ST_PARITY: perr_q <= SIN ^ (^data_q);
        default:   ;
      endcase
    end
  end

  assign push_entry = {data_q, perr_q, ~SIN};

  ms_uart_rxfifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .internalclk (internalclk),
    .RESETN      (RESETN),
    .push        (push),
    .pop         (RD),
    .din         (push_entry),
    .dout        (head),
    .empty       (EMPTY),
    .full        (FULL),
    .ovf         (ovf)
  );

  assign DOUT = head[EW-1:2];
  assign PERR = head[1];
  assign FERR = head[0];
  assign OVR  = ovr_q;
  assign BUSY = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ms_uart_bitrx.sv
// Directed and randomized frames against a queue-based model of the receive path.
module tb_ms_uart_bitrx;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic          internalclk = 1'b0;
  logic          RESETN = 1'b1;
  logic          SIN = 1'b1;
  logic          RD = 1'b0;
  logic [DB-1:0] DOUT;
  logic          PERR, FERR, EMPTY, FULL, OVR, BUSY;

  int tests = 0;
  int fails = 0;
  logic [DB+1:0] mq[$];
  bit movr = 1'b0;

  ms_uart_bitrx #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .internalclk (internalclk),
    .RESETN      (RESETN),
    .SIN         (SIN),
    .RD          (RD),
    .DOUT        (DOUT),
    .PERR        (PERR),
    .FERR        (FERR),
    .EMPTY       (EMPTY),
    .FULL        (FULL),
    .OVR         (OVR),
    .BUSY        (BUSY)
  );

  always #5 internalclk = ~internalclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [DB+1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, " EMPTY"}, 32'(EMPTY), 32'(mq.size() == 0));
    chk({tag, " FULL"},  32'(FULL),  32'(mq.size() == DEPTH));
    chk({tag, " OVR"},   32'(OVR),   32'(movr));
    chk({tag, " DOUT"},  32'(DOUT),  32'(h[DB+1:2]));
    chk({tag, " PERR"},  32'(PERR),  32'(h[1]));
    chk({tag, " FERR"},  32'(FERR),  32'(h[0]));
  endtask

  task automatic tick();
    @(posedge internalclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SIN = b;
    tick();
  endtask

  // bad_par flips the parity bit; expected PERR is exactly that flag.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit stop,
                            input bit rd, input int extra_low);
    logic pbit;
    pbit = (^d) ^ bad_par;
    send_bit(1'b0);
    chk("start BUSY", 32'(BUSY), 32'd1);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(pbit);
    check_model("pre-stop");
    chk("parity BUSY", 32'(BUSY), 32'd1);
    RD  = rd;
    SIN = stop;
    tick();
    RD = 1'b0;
    if (rd && mq.size() != 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) mq.push_back({d, bad_par, ~stop});
    else movr = 1'b1;
    check_model("stop");
    chk("stop BUSY", 32'(BUSY), 32'(!stop));
    if (!stop) begin
      for (int k = 0; k < extra_low; k++) begin
        send_bit(1'b0);
        chk("low BUSY", 32'(BUSY), 32'd1);
        check_model("low");
      end
      send_bit(1'b1);
      chk("idle BUSY", 32'(BUSY), 32'd0);
    end
  endtask

  task automatic read_one();
    RD = 1'b1;
    tick();
    RD = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check_model("read");
  endtask

  task automatic do_reset();
    RESETN = 1'b1;
    mq.delete();
    movr = 1'b0;
    #2;
    check_model("reset");
    chk("reset BUSY", 32'(BUSY), 32'd0);
    RESETN = 1'b0;
  endtask

  initial begin
    #12;
    check_model("por");
    chk("por BUSY", 32'(BUSY), 32'd0);
    RESETN = 1'b0;
    tick();

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    read_one();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0);
    read_one();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3);
    read_one();

    for (int i = 0; i < 5; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) read_one();

    tick();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h15, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) read_one();

    // Abort a frame after data bit 3 and confirm a clean restart.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    send_bit(1'b1);
    chk("post-reset BUSY", 32'(BUSY), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
    read_one();

    for (int n = 0; n < 60; n++) begin
      logic [DB-1:0] d;
      d = DB'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) read_one();
      repeat ($urandom_range(0, 1)) begin
        send_bit(1'b1);
        check_model("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
